systolic_result_drain: RTL and testbench

Reader end of the systolic array result interface. Snapshots the SIZE x SIZE accumulator matrix on the array-control done pulse, which is the last cycle before the array is cleared. Streams the valid QxK sub-matrix out one element per beat over a valid/ready handshake. Sits between the systolic array top and the result memory or bus adapter.

---
 rtl/systolic_result_drain_pkg.sv | 22 ++
 rtl/systolic_result_drain_index_counter.sv | 53 +++++
 rtl/systolic_result_drain.sv | 115 +++++++++++
 tb/tb_systolic_result_drain.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_drain_pkg.sv
// Shared constants, drain state encoding and flat-matrix element addressing
// for the systolic array result drain.
package systolic_result_drain_pkg;

  localparam int unsigned DATAWIDTH = 16;
  localparam int unsigned SIZE      = 4;
  localparam int unsigned DIMW      = $clog2(SIZE) + 1;

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

  // Bit offset of element (i,j) inside the flattened accumulator bus.
  function automatic int unsigned elem_offset(input int unsigned i,
                                              input int unsigned j,
                                              input int unsigned size  = SIZE,
                                              input int unsigned width = DATAWIDTH);
    return (i * size + j) * width;
  endfunction

endpackage

// File: rtl/systolic_result_drain_index_counter.sv
// 2-D row/col index counter with runtime limits q (rows) and k (cols),
// selectable row-major or column-major advance, and a last-element flag.
module drain_index_counter
  import systolic_result_drain_pkg::*;
#(
  parameter int unsigned IDXW = DIMW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            adv,
  input  logic            col_major,
  input  logic [IDXW-1:0] q,
  input  logic [IDXW-1:0] k,
  output logic [IDXW-1:0] row,
  output logic [IDXW-1:0] col,
  output logic            last
);

  logic row_end;
  logic col_end;

  assign row_end = (row == q - IDXW'(1));
  assign col_end = (col == k - IDXW'(1));
  assign last    = row_end & col_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col_major) begin
        if (row_end) begin
          row <= '0;
          col <= col_end ? '0 : col + IDXW'(1);
        end else begin
          row <= row + IDXW'(1);
        end
      end else begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + IDXW'(1);
        end else begin
          col <= col + IDXW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the accumulator matrix on done and streams the QxK result over
// valid/ready. Define DRAIN_COLMAJOR_EN for column-major streaming order.
module systolic_result_drain #(
  parameter int unsigned DATAWIDTH = systolic_result_drain_pkg::DATAWIDTH,
  parameter int unsigned SIZE      = systolic_result_drain_pkg::SIZE,
  parameter int unsigned DIMW      = $clog2(SIZE) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           done,
  input  logic [DIMW-1:0]                depth_A,
  input  logic [DIMW-1:0]                width_B,
  input  logic [SIZE*SIZE*DATAWIDTH-1:0] dout_flat,
  output logic [DATAWIDTH-1:0]           m_data,
  output logic [DIMW-1:0]                m_row,
  output logic [DIMW-1:0]                m_col,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           busy,
  output logic                           overrun,
  input  logic                           clr_overrun
);
  import systolic_result_drain_pkg::*;

  localparam int unsigned NEL  = SIZE * SIZE;
  localparam int unsigned RIDX = $clog2(NEL);

`ifdef DRAIN_COLMAJOR_EN
  localparam logic COL_MAJOR = 1'b1;
`else
  localparam logic COL_MAJOR = 1'b0;
`endif

  drain_state_t         state, state_nx;
  logic [DATAWIDTH-1:0] elems [NEL];
  logic [DATAWIDTH-1:0] snap  [NEL];
  logic [DIMW-1:0]      q_clamp, k_clamp;
  logic [DIMW-1:0]      q_r, k_r;
  logic [RIDX-1:0]      rd_idx;
  logic                 capture;
  logic                 overrun_set;
  logic                 beat;
  logic                 idx_last;

  for (genvar e = 0; e < NEL; e++) begin : g_unpack
    localparam int unsigned OFF =
      elem_offset(int'(e) / SIZE, int'(e) % SIZE, SIZE, DATAWIDTH);
    assign elems[e] = dout_flat[OFF +: DATAWIDTH];
  end

  assign q_clamp = (depth_A > DIMW'(SIZE)) ? DIMW'(SIZE) : depth_A;
  assign k_clamp = (width_B > DIMW'(SIZE)) ? DIMW'(SIZE) : width_B;

  assign m_valid = (state == STREAM);
  assign busy    = (state == STREAM);
  assign beat    = m_valid & m_ready;
  assign m_last  = m_valid & idx_last;
  assign rd_idx  = RIDX'(m_row * SIZE + m_col);
  assign m_data  = snap[rd_idx];

  drain_index_counter #(
    .IDXW (DIMW)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clear     (capture),
    .adv       (beat),
    .col_major (COL_MAJOR),
    .q         (q_r),
    .k         (k_r),
    .row       (m_row),
    .col       (m_col),
    .last      (idx_last)
  );

  always_comb begin
    state_nx    = state;
    capture     = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (done) begin
          capture = 1'b1;
          if (q_clamp != '0 && k_clamp != '0) state_nx = STREAM;
        end
      end
      STREAM: begin
        overrun_set = done;
        if (m_ready && idx_last) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      snap    <= '{default: '0};
      q_r     <= '0;
      k_r     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (capture) begin
        snap <= elems;
        q_r  <= q_clamp;
        k_r  <= k_clamp;
      end
      // A new event in the same cycle as a clear keeps the flag set.
      if (overrun_set)      overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized self-checking bench for systolic_result_drain against a
// queue-based reference model of the expected beat sequence.
module tb_systolic_result_drain;
  import systolic_result_drain_pkg::*;

  logic                           clk = 1'b0;
  logic                           reset = 1'b0;
  logic                           done = 1'b0;
  logic [DIMW-1:0]                depth_A = '0;
  logic [DIMW-1:0]                width_B = '0;
  logic [SIZE*SIZE*DATAWIDTH-1:0] dout_flat = '0;
  logic [DATAWIDTH-1:0]           m_data;
  logic [DIMW-1:0]                m_row, m_col;
  logic                           m_valid, m_ready = 1'b0, m_last;
  logic                           busy, overrun, clr_overrun = 1'b0;

  systolic_result_drain #(
    .DATAWIDTH (DATAWIDTH),
    .SIZE      (SIZE),
    .DIMW      (DIMW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .done        (done),
    .depth_A     (depth_A),
    .width_B     (width_B),
    .dout_flat   (dout_flat),
    .m_data      (m_data),
    .m_row       (m_row),
    .m_col       (m_col),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATAWIDTH-1:0] d;
    int                   r;
    int                   c;
    bit                   last;
  } beat_t;

  beat_t                exp_q[$];
  bit                   exp_ovr = 1'b0;
  logic [DATAWIDTH-1:0] cur [SIZE][SIZE];
  int                   checks = 0;
  int                   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (exp_q.size() != 0);
    check("m_valid", 32'(m_valid), 32'(v));
    check("busy", 32'(busy), 32'(v));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    if (v) begin
      check("m_data", 32'(m_data), 32'(exp_q[0].d));
      check("m_row", 32'(m_row), exp_q[0].r);
      check("m_col", 32'(m_col), exp_q[0].c);
      check("m_last", 32'(m_last), 32'(exp_q[0].last));
    end
  endtask

  // Expected beat list from the clamped dims and the current matrix.
  task automatic load(input int q, input int k);
    int qq, kk;
    beat_t b;
    qq = (q > int'(SIZE)) ? int'(SIZE) : q;
    kk = (k > int'(SIZE)) ? int'(SIZE) : k;
    for (int idx = 0; idx < qq * kk; idx++) begin
`ifdef DRAIN_COLMAJOR_EN
      b.r = idx % qq;
      b.c = idx / qq;
`else
      b.r = idx / kk;
      b.c = idx % kk;
`endif
      b.d    = cur[b.r][b.c];
      b.last = (idx == qq * kk - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model. pat=1 gives 16*i+j data.
  task automatic step(input bit d, input int q, input int k, input bit rdy,
                      input bit clr, input int pat);
    bit was_busy;
    check_outputs();
    done        = d;
    depth_A     = DIMW'(q);
    width_B     = DIMW'(k);
    m_ready     = rdy;
    clr_overrun = clr;
    for (int i = 0; i < int'(SIZE); i++) begin
      for (int j = 0; j < int'(SIZE); j++) begin
        cur[i][j] = (pat == 1) ? DATAWIDTH'(16 * i + j) : DATAWIDTH'($urandom);
        dout_flat[(i * int'(SIZE) + j) * int'(DATAWIDTH) +: DATAWIDTH] = cur[i][j];
      end
    end
    was_busy = (exp_q.size() != 0);
    if (was_busy && rdy) void'(exp_q.pop_front());
    if (d && !was_busy) load(q, k);
    if (d && was_busy) exp_ovr = 1'b1;
    else if (clr)      exp_ovr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_row", 32'(m_row), 32'd0);
    check("rst_m_col", 32'(m_col), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Full 4x4, ready held high
    step(1, 4, 4, 1, 0, 1);
    repeat (18) step(0, 0, 0, 1, 0, 0);

    // 2x3 sub-matrix with backpressure
    step(1, 2, 3, 1, 0, 0);
    for (int n = 0; n < 20; n++) step(0, 0, 0, (n % 3) == 0, 0, 0);

    // Degenerate and clamped dimensions
    step(1, 0, 3, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 3, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 5, 5, 1, 0, 0);
    repeat (18) step(0, 0, 0, 1, 0, 0);

    // 2x2 order check
    step(1, 2, 2, 1, 0, 0);
    repeat (6) step(0, 0, 0, 1, 0, 0);

    // Overrun at beat 3, then clear
    step(1, 4, 4, 1, 0, 1);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    step(1, 4, 4, 1, 0, 0);
    repeat (15) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);

    // Done on the final beat, with a simultaneous clear
    step(1, 1, 2, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 3, 3, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);

    // Reset during beat 5
    step(1, 4, 4, 1, 0, 1);
    repeat (4) step(0, 0, 0, 1, 0, 0);
    check_outputs();
    #2 reset = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_m_row", 32'(m_row), 32'd0);
    check("midrst_m_col", 32'(m_col), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    exp_q.delete();
    exp_ovr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    step(1, 3, 2, 1, 0, 0);
    repeat (8) step(0, 0, 0, 1, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 6) == 0, int'($urandom % 8), int'($urandom % 8),
           ($urandom % 4) != 0, ($urandom % 10) == 0, 0);
    end
    repeat (20) step(0, 0, 0, 1, 1, 0);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
